// File: rtl/fetch_pair_sequencer.sv
// fetch_pair_sequencer
//   Owns the fetch PC for the dual-issue front end. It issues aligned 8-byte
//   pair reads to instruction memory and buffers the returned pairs in a small
//   queue. The queue head is presented to dual decode over valid/ready.
//   An unloaded memory word marks end of program: fetch drains, then reports
//   finish. A branch redirect flushes the queue and any read in flight.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin fetching at START_PC (accepted in IDLE/DONE)
//   redirect_valid/pc  branch/jump redirect; target is aligned down to 4
//   imem_req/addr      pair read request; addr = byte address of slot 0
//   imem_rdata/rvalid  pair data {word@addr, word@addr+4} and per-word loaded
//                      flags; both arrive one cycle after imem_req
//   out_valid/ready    decode handshake for the queue head
//   out_instr1/2       slot 0 / slot 1 instruction (instr2 is 0 if mask is 01)
//   out_mask/pc        valid slots (11 or 01), byte address of slot 0
//   finish             sticky program-complete flag
//   busy               high while fetching or draining
//   perf_instr_cnt     instructions handed to decode (FETCH_PERF_EN)
//   perf_stall_cnt     cycles the head waited on decode (FETCH_PERF_EN)
//
// Build option: define FETCH_PERF_EN to get the saturating perf counters.
// When it is not defined, the perf ports are tied to 0.
module fetch_pair_sequencer #(
    parameter int          PC_W     = 8,
    parameter int          DEPTH    = 2,
    parameter int unsigned START_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [63:0]     imem_rdata,
    input  logic [1:0]      imem_rvalid,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr1,
    output logic [31:0]     out_instr2,
    output logic [1:0]      out_mask,
    output logic [PC_W-1:0] out_pc,
    output logic            finish,
    output logic            busy,
    output logic [15:0]     perf_instr_cnt,
    output logic [15:0]     perf_stall_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PC_W-1:0] START_ALIGNED = PC_W'(START_PC) & ~PC_W'(3);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_inf_pc;     // slot-0 address of the read in flight
    logic            r_inflight;   // a read was issued last cycle
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_cnt;

    logic [31:0]     r_q_i1   [DEPTH];
    logic [31:0]     r_q_i2   [DEPTH];
    logic [1:0]      r_q_mask [DEPTH];
    logic [PC_W-1:0] r_q_pc   [DEPTH];

    logic w_rsp, w_enq, w_stop, w_deq, w_start_acc, w_room;

    // Occupancy counts reads in flight so an issued read always has a slot
    // when it returns; this uses only registered state, so out_ready never
    // reaches imem_req combinationally.
    assign w_room      = (int'(r_cnt) + int'(r_inflight)) < DEPTH;
    assign imem_req    = (r_state == S_RUN) && !redirect_valid && w_room;
    assign imem_addr   = imem_req ? r_pc : '0;

    // Responses count only while still in RUN; redirect kills the one in flight.
    assign w_rsp       = r_inflight && (r_state == S_RUN) && !redirect_valid;
    assign w_enq       = w_rsp && imem_rvalid[0];
    assign w_stop      = w_rsp && (imem_rvalid != 2'b11);
    assign w_deq       = out_valid && out_ready && !redirect_valid;
    assign w_start_acc = start && !redirect_valid &&
                         ((r_state == S_IDLE) || (r_state == S_DONE));

    always_comb begin
        w_state_nxt = r_state;
        if (redirect_valid) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  if (start) w_state_nxt = S_RUN;
                S_RUN:   if (w_stop) w_state_nxt = S_DRAIN;
                S_DRAIN: if ((r_cnt == '0) && !r_inflight) w_state_nxt = S_DONE;
                S_DONE:  if (start) w_state_nxt = S_RUN;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= START_ALIGNED;
            r_inf_pc   <= '0;
            r_inflight <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_inf_pc <= r_pc;
                r_pc     <= r_pc + PC_W'(8);
            end
            if (redirect_valid) begin
                r_pc       <= redirect_pc & ~PC_W'(3);
                r_inflight <= 1'b0;
                r_wptr     <= '0;
                r_rptr     <= '0;
                r_cnt      <= '0;
            end else begin
                if (w_start_acc) r_pc <= START_ALIGNED;
                if (w_enq) r_wptr <= r_wptr + AW'(1);
                if (w_deq) r_rptr <= r_rptr + AW'(1);
                case ({w_enq, w_deq})
                    2'b10:   r_cnt <= r_cnt + CW'(1);
                    2'b01:   r_cnt <= r_cnt - CW'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

    // Queue storage needs no reset: out_* are gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_q_i1[r_wptr]   <= imem_rdata[63:32];
            r_q_i2[r_wptr]   <= imem_rvalid[1] ? imem_rdata[31:0] : 32'h0;
            r_q_mask[r_wptr] <= imem_rvalid[1] ? 2'b11 : 2'b01;
            r_q_pc[r_wptr]   <= r_inf_pc;
        end
    end

    assign out_valid  = (r_cnt != '0);
    assign out_instr1 = out_valid ? r_q_i1[r_rptr]   : '0;
    assign out_instr2 = out_valid ? r_q_i2[r_rptr]   : '0;
    assign out_mask   = out_valid ? r_q_mask[r_rptr] : '0;
    assign out_pc     = out_valid ? r_q_pc[r_rptr]   : '0;
    assign finish     = (r_state == S_DONE);
    assign busy       = (r_state == S_RUN) || (r_state == S_DRAIN);

`ifdef FETCH_PERF_EN
    logic [15:0] r_perf_instr, r_perf_stall;
    logic [16:0] w_instr_sum;

    assign w_instr_sum = {1'b0, r_perf_instr} + ((out_mask == 2'b11) ? 17'd2 : 17'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_instr <= '0;
            r_perf_stall <= '0;
        end else if (w_start_acc) begin
            r_perf_instr <= '0;
            r_perf_stall <= '0;
        end else begin
            if (out_valid && out_ready)
                r_perf_instr <= w_instr_sum[16] ? 16'hFFFF : w_instr_sum[15:0];
            if (out_valid && !out_ready && (r_perf_stall != 16'hFFFF))
                r_perf_stall <= r_perf_stall + 16'd1;
        end
    end

    assign perf_instr_cnt = r_perf_instr;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_instr_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_pair_sequencer.sv
module tb_fetch_pair_sequencer;
    logic        clk, rst_n, start, redirect_valid, out_ready;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [63:0] imem_rdata;
    logic [1:0]  imem_rvalid;
    logic        out_valid, finish, busy;
    logic [31:0] out_instr1, out_instr2;
    logic [1:0]  out_mask;
    logic [7:0]  out_pc;
    logic [15:0] perf_instr_cnt, perf_stall_cnt;

    fetch_pair_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr1(out_instr1), .out_instr2(out_instr2),
        .out_mask(out_mask), .out_pc(out_pc),
        .finish(finish), .busy(busy),
        .perf_instr_cnt(perf_instr_cnt), .perf_stall_cnt(perf_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory image: every word has a distinct address-derived value; ld marks
    // which 32-bit words are loaded.
    logic [63:0] ld;
    logic        r_pend;
    logic [7:0]  r_addr, a2;

    function automatic logic [31:0] word_of(input logic [7:0] a);
        return {8'hC3, a, ~a, 8'h5A};
    endfunction

    always @(posedge clk) begin
        r_pend <= imem_req;
        r_addr <= imem_addr;
    end

    always_comb begin
        a2          = r_addr + 8'd4;
        imem_rdata  = 64'hBAD0_BAD0_BAD1_BAD1;
        imem_rvalid = 2'b00;
        if (r_pend) begin
            imem_rdata  = {word_of(r_addr), word_of(a2)};
            imem_rvalid = {ld[a2[7:2]], ld[r_addr[7:2]]};
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected decode-side pairs, in order.
    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [1:0]  mask;
    } pair_t;
    pair_t sb[$];

    task automatic push_pair(input logic [7:0] pc, input bit full);
        pair_t p;
        p.pc   = pc;
        p.i1   = word_of(pc);
        p.i2   = full ? word_of(pc + 8'd4) : 32'h0;
        p.mask = full ? 2'b11 : 2'b01;
        sb.push_back(p);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pair actual_pc=%0h expected=none", out_pc);
            end else begin
                pair_t e;
                e = sb.pop_front();
                chk("pair_pc",   64'(out_pc),     64'(e.pc));
                chk("pair_i1",   64'(out_instr1), 64'(e.i1));
                chk("pair_i2",   64'(out_instr2), 64'(e.i2));
                chk("pair_mask", 64'(out_mask),   64'(e.mask));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_finish(input int budget, input string name);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (finish === 1'b1) break;
        end
        chk(name, 64'(finish), 64'd1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_req"},    64'(imem_req),   64'd0);
        chk({name, "_addr"},   64'(imem_addr),  64'd0);
        chk({name, "_valid"},  64'(out_valid),  64'd0);
        chk({name, "_i1"},     64'(out_instr1), 64'd0);
        chk({name, "_i2"},     64'(out_instr2), 64'd0);
        chk({name, "_mask"},   64'(out_mask),   64'd0);
        chk({name, "_pc"},     64'(out_pc),     64'd0);
        chk({name, "_finish"}, 64'(finish),     64'd0);
        chk({name, "_busy"},   64'(busy),       64'd0);
    endtask

    // Program-length scenarios: loaded words from 0x00, pairs expected at
    // decode, and whether the last pair has both slots.
    typedef struct {
        int nwords;
        int npairs;
        bit last_full;
    } vec_t;
    localparam int NV = 6;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  exp_addr[3];
        logic [7:0]  got_addr[3];
        logic [31:0] head_i1;
        logic [7:0]  head_pc;
        bit          have_head;
        int          nreq, nstall, ngot;

        vecs[0] = '{4, 2, 1'b1};
        vecs[1] = '{3, 2, 1'b0};
        vecs[2] = '{1, 1, 1'b0};
        vecs[3] = '{2, 1, 1'b1};
        vecs[4] = '{0, 0, 1'b0};
        vecs[5] = '{5, 3, 1'b0};

        rst_n = 1'b0; start = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 8'h00; out_ready = 1'b1; ld = '0;
        #1;
        chk_all_zero("reset");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Table: program lengths, start latency, drain and finish.
        for (int v = 0; v < NV; v++) begin
            ld = '0;
            for (int w = 0; w < vecs[v].nwords; w++) ld[w] = 1'b1;
            out_ready = 1'b1;
            for (int k = 0; k < vecs[v].npairs; k++)
                push_pair(8'(8 * k), (k < vecs[v].npairs - 1) || vecs[v].last_full);
            start = 1'b1;
            tick();
            start = 1'b0;
            @(negedge clk);
            chk("lat_req_t1",  64'(imem_req),  64'd1);
            chk("lat_addr_t1", 64'(imem_addr), 64'd0);
            chk("finish_clr",  64'(finish),    64'd0);
            chk("busy_run",    64'(busy),      64'd1);
            @(negedge clk);
            chk("lat_valid_t2", 64'(out_valid), 64'd0);
            @(negedge clk);
            chk("lat_valid_t3", 64'(out_valid), 64'(vecs[v].npairs > 0));
            wait_finish(60, "vec_finish");
            chk("vec_busy_done", 64'(busy), 64'd0);
            chk("vec_sb_empty",  64'(sb.size()), 64'd0);
`ifdef FETCH_PERF_EN
            chk("perf_instr", 64'(perf_instr_cnt), 64'(vecs[v].nwords));
`endif
            tick();
        end

        // Backpressure: decode stalls 10 cycles after start.
        ld = '0;
        for (int w = 0; w < 8; w++) ld[w] = 1'b1;
        for (int k = 0; k < 4; k++) push_pair(8'(8 * k), 1'b1);
        out_ready = 1'b0;
        nreq = 0; nstall = 0; have_head = 1'b0;
        head_i1 = '0; head_pc = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req) nreq++;
            if (out_valid) begin
                nstall++;
                if (!have_head) begin
                    have_head = 1'b1;
                    head_i1 = out_instr1;
                    head_pc = out_pc;
                    chk("stall_head_pc", 64'(out_pc), 64'h00);
                end else begin
                    chk("stall_head_pc_stable", 64'(out_pc),     64'(head_pc));
                    chk("stall_head_i1_stable", 64'(out_instr1), 64'(head_i1));
                end
            end
            tick();
        end
        chk("stall_reads", 64'(nreq), 64'd2);
        chk("stall_saw_head", 64'(have_head), 64'd1);
        out_ready = 1'b1;
        @(negedge clk);
`ifdef FETCH_PERF_EN
        chk("perf_stall", 64'(perf_stall_cnt), 64'(nstall));
`endif
        wait_finish(60, "stall_finish");
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);
        tick();

        // Redirect while the first read is in flight.
        ld = '0;
        for (int w = 16; w < 20; w++) ld[w] = 1'b1;
        push_pair(8'h40, 1'b1);
        push_pair(8'h48, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("redir_first_req", 64'(imem_req), 64'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 8'h42;
        @(negedge clk);
        chk("redir_req_blocked", 64'(imem_req), 64'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_req",   64'(imem_req),  64'd1);
        chk("redir_addr",  64'(imem_addr), 64'h40);
        chk("redir_flush", 64'(out_valid), 64'd0);
        wait_finish(60, "redir_finish");
        chk("redir_sb_empty", 64'(sb.size()), 64'd0);
        tick();

        // PC wrap through a fully loaded memory; misaligned target.
        ld = '1;
        for (int k = 0; k < 8; k++) push_pair(8'(8'hF8 + 8 * k), 1'b1);
        exp_addr[0] = 8'hF8; exp_addr[1] = 8'h00; exp_addr[2] = 8'h08;
        redirect_valid = 1'b1;
        redirect_pc = 8'hFB;
        tick();
        redirect_valid = 1'b0;
        ngot = 0;
        for (int c = 0; c < 20 && ngot < 3; c++) begin
            @(negedge clk);
            if (imem_req) begin
                got_addr[ngot] = imem_addr;
                ngot++;
            end
        end
        chk("wrap_nreq", 64'(ngot), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < ngot) chk("wrap_addr", 64'(got_addr[i]), 64'(exp_addr[i]));

        // Fill the queue, then reset asynchronously mid-cycle.
        tick();
        out_ready = 1'b0;
        repeat (6) tick();
        chk("full_valid", 64'(out_valid), 64'd1);
        chk("full_busy",  64'(busy),      64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post_rst_req",   64'(imem_req),  64'd0);
            chk("post_rst_busy",  64'(busy),      64'd0);
            chk("post_rst_valid", 64'(out_valid), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
